// File: rtl/n2_btb_upd_sched_pkg.sv
// Shared types for the mBTB write-side scheduler: the BTB entry layout,
// the scheduler FSM state encoding and the entry packing helper.
package n2_btb_upd_sched_pkg;

  localparam int BTB_ENTRY_W = 34;

  typedef struct packed {
    logic        valid;
    logic        is_jarl;
    logic [15:0] pc;
    logic [15:0] tgt;
  } btb_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    INV  = 2'd2
  } btb_sched_st_t;

  // RAM word layout: {valid, is_jarl, pc, tgt}
  function automatic logic [BTB_ENTRY_W-1:0] btb_pack(input btb_t e);
    return {e.valid, e.is_jarl, e.pc, e.tgt};
  endfunction

endpackage

// File: rtl/n2_btb_upd_sched_fifo.sv
// Per-bank update queue: two pushes (slot 0 is older) and one pop per cycle.
// Pushes that do not fit are dropped, slot 1 first; a same-cycle pop frees
// a slot. Pointers carry one extra wrap bit so full/empty need no counter.
module n2_btb_upd_fifo
  import n2_btb_upd_sched_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int W      = BTB_ENTRY_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_flush,
  input  logic         i_push0_v,
  input  logic [W-1:0] i_push0_d,
  input  logic         i_push1_v,
  input  logic [W-1:0] i_push1_d,
  input  logic         i_pop,
  output logic         o_empty,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_drop
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [W-1:0]  r_mem [QDEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic [PW-1:0] w_cnt;
  logic [PW-1:0] w_free;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_wr_a;
  logic          w_wr_b;
  logic [W-1:0]  w_wr_a_d;
  logic [AW-1:0] w_wr_idx;
  logic [PW-1:0] w_nacc;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop & ~w_empty;
  assign w_cnt   = r_wr - r_rd;

  // Free slots this cycle, counting the slot released by a same-cycle pop
  always_comb begin
    w_free = {{(PW-1){1'b0}}, w_pop};
    if (!w_full)
      w_free = PW'(QDEPTH) - w_cnt + {{(PW-1){1'b0}}, w_pop};
  end

  // Accept the older push first; the younger one only if a second slot is free
  always_comb begin
    w_acc0   = i_push0_v && (w_free != '0);
    w_acc1   = i_push1_v && (w_free > {{(PW-1){1'b0}}, w_acc0});
    w_wr_a   = w_acc0 | w_acc1;
    w_wr_b   = w_acc0 & w_acc1;
    w_wr_a_d = w_acc0 ? i_push0_d : i_push1_d;
    w_wr_idx = r_wr[AW-1:0] + AW'(1);
    w_nacc   = {{(PW-1){1'b0}}, w_acc0} + {{(PW-1){1'b0}}, w_acc1};
    o_drop   = {1'b0, i_push0_v & ~w_acc0} + {1'b0, i_push1_v & ~w_acc1};
  end

  // Queue pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + w_nacc;
      r_rd <= r_rd + {{(PW-1){1'b0}}, w_pop};
    end
  end

  // Entry storage, written in push order
  always_ff @(posedge clk) begin
    if (w_wr_a) r_mem[r_wr[AW-1:0]] <= w_wr_a_d;
    if (w_wr_b) r_mem[w_wr_idx]     <= i_push1_d;
  end

  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/n2_btb_upd_sched.sv
// mBTB write scheduler: routes EX/D2 branch updates to the bank selected by
// pc[2], queues them per bank, and sweeps the table to zero after reset and
// on invalidate-all. Bank write ports are driven from registers.
module n2_btb_upd_sched
  import n2_btb_upd_sched_pkg::*;
#(
  parameter  int NUM_mBTB = 512,
  parameter  int QDEPTH   = 4,
  parameter  int DROP_W   = 8,
  localparam int ADDR_W   = $clog2(NUM_mBTB)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   upd_ex_v_i,
  input  btb_t                   upd_ex_i,
  input  logic                   upd_d2_v_i,
  input  btb_t                   upd_d2_i,
  input  logic                   inv_all_i,
  output logic                   wren_b0_o,
  output logic                   wren_b1_o,
  output logic [ADDR_W-1:0]      addr_b0_o,
  output logic [ADDR_W-1:0]      addr_b1_o,
  output logic [BTB_ENTRY_W-1:0] wdata_b0_o,
  output logic [BTB_ENTRY_W-1:0] wdata_b1_o,
  output logic                   init_done_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);

  btb_sched_st_t          r_state;
  btb_sched_st_t          w_state_nxt;
  logic [ADDR_W-1:0]      r_cnt;
  logic                   r_init_done;
  logic [DROP_W-1:0]      r_drop_cnt;
  logic                   r_wren_b0;
  logic                   r_wren_b1;
  logic [ADDR_W-1:0]      r_addr_b0;
  logic [ADDR_W-1:0]      r_addr_b1;
  logic [BTB_ENTRY_W-1:0] r_wdata_b0;
  logic [BTB_ENTRY_W-1:0] r_wdata_b1;

  logic                   w_sweep;
  logic                   w_sweep_last;
  logic                   w_upd_ok;
  logic                   w_inv_go;
  logic                   w_ex_b1;
  logic                   w_d2_b1;
  logic [BTB_ENTRY_W-1:0] w_ex_d;
  logic [BTB_ENTRY_W-1:0] w_d2_d;
  logic                   w_empty0;
  logic                   w_empty1;
  logic [BTB_ENTRY_W-1:0] w_head0_raw;
  logic [BTB_ENTRY_W-1:0] w_head1_raw;
  btb_t                   w_head0;
  btb_t                   w_head1;
  logic [1:0]             w_drop0;
  logic [1:0]             w_drop1;
  logic                   w_pop0;
  logic                   w_pop1;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [2:0]        b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-2){1'b0}}, b};
    return s[DROP_W] ? '1 : s[DROP_W-1:0];
  endfunction

  assign w_sweep      = (r_state != RUN);
  assign w_sweep_last = (r_cnt == ADDR_W'(NUM_mBTB - 1));
  assign w_upd_ok     = (r_state == RUN) & ~inv_all_i;
  assign w_inv_go     = (r_state == RUN) &  inv_all_i;
  assign w_ex_b1      = upd_ex_i.pc[2];
  assign w_d2_b1      = upd_d2_i.pc[2];
  assign w_ex_d       = btb_pack(upd_ex_i);
  assign w_d2_d       = btb_pack(upd_d2_i);
  assign w_pop0       = w_upd_ok & ~w_empty0;
  assign w_pop1       = w_upd_ok & ~w_empty1;
  assign w_head0      = btb_t'(w_head0_raw);
  assign w_head1      = btb_t'(w_head1_raw);

  n2_btb_upd_fifo #(.QDEPTH(QDEPTH), .W(BTB_ENTRY_W)) u_q0 (
    .clk       (clk),
    .resetn    (resetn),
    .i_flush   (w_inv_go),
    .i_push0_v (upd_ex_v_i & w_upd_ok & ~w_ex_b1),
    .i_push0_d (w_ex_d),
    .i_push1_v (upd_d2_v_i & w_upd_ok & ~w_d2_b1),
    .i_push1_d (w_d2_d),
    .i_pop     (w_pop0),
    .o_empty   (w_empty0),
    .o_head    (w_head0_raw),
    .o_drop    (w_drop0)
  );

  n2_btb_upd_fifo #(.QDEPTH(QDEPTH), .W(BTB_ENTRY_W)) u_q1 (
    .clk       (clk),
    .resetn    (resetn),
    .i_flush   (w_inv_go),
    .i_push0_v (upd_ex_v_i & w_upd_ok & w_ex_b1),
    .i_push0_d (w_ex_d),
    .i_push1_v (upd_d2_v_i & w_upd_ok & w_d2_b1),
    .i_push1_d (w_d2_d),
    .i_pop     (w_pop1),
    .o_empty   (w_empty1),
    .o_head    (w_head1_raw),
    .o_drop    (w_drop1)
  );

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= INIT;
    else         r_state <= w_state_nxt;
  end

  // Next state: sweeps end after the last address, invalidate restarts a sweep
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT, INV: if (w_sweep_last) w_state_nxt = RUN;
      RUN:       if (inv_all_i)    w_state_nxt = INV;
      default:   w_state_nxt = INIT;
    endcase
  end

  // Sweep address counter, drop counter and init-done flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_sweep)       r_cnt <= w_sweep_last ? '0 : r_cnt + ADDR_W'(1);
      else if (w_inv_go) r_cnt <= '0;
      r_init_done <= (r_state == RUN) & ~inv_all_i;
      r_drop_cnt  <= sat_add(r_drop_cnt, {1'b0, w_drop0} + {1'b0, w_drop1});
    end
  end

  // Write ports: zero sweep, else queue head; address/data hold while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wren_b0  <= 1'b0;
      r_wren_b1  <= 1'b0;
      r_addr_b0  <= '0;
      r_addr_b1  <= '0;
      r_wdata_b0 <= '0;
      r_wdata_b1 <= '0;
    end else if (w_sweep) begin
      r_wren_b0  <= 1'b1;
      r_wren_b1  <= 1'b1;
      r_addr_b0  <= r_cnt;
      r_addr_b1  <= r_cnt;
      r_wdata_b0 <= '0;
      r_wdata_b1 <= '0;
    end else begin
      r_wren_b0 <= w_pop0;
      r_wren_b1 <= w_pop1;
      if (w_pop0) begin
        r_addr_b0  <= w_head0.pc[3 +: ADDR_W];
        r_wdata_b0 <= w_head0_raw;
      end
      if (w_pop1) begin
        r_addr_b1  <= w_head1.pc[3 +: ADDR_W];
        r_wdata_b1 <= w_head1_raw;
      end
    end
  end

  assign wren_b0_o   = r_wren_b0;
  assign wren_b1_o   = r_wren_b1;
  assign addr_b0_o   = r_addr_b0;
  assign addr_b1_o   = r_addr_b1;
  assign wdata_b0_o  = r_wdata_b0;
  assign wdata_b1_o  = r_wdata_b1;
  assign init_done_o = r_init_done;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_n2_btb_upd_sched.sv
// Directed bench for the mBTB write scheduler: reset sweep, bank routing,
// same-bank ordering, overflow/saturation, invalidate and reset mid-sweep.
module tb_n2_btb_upd_sched;
  import n2_btb_upd_sched_pkg::*;

  localparam int NUM = 512;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        upd_ex_v_i, upd_d2_v_i, inv_all_i;
  btb_t        upd_ex_i, upd_d2_i;
  logic        wren_b0_o, wren_b1_o, init_done_o;
  logic [8:0]  addr_b0_o, addr_b1_o;
  logic [33:0] wdata_b0_o, wdata_b1_o;
  logic [7:0]  drop_cnt_o;

  int n_err = 0;
  int n_chk = 0;

  logic [33:0] exp_w [8];
  logic [8:0]  exp_a [8];
  logic [8:0]  a;

  n2_btb_upd_sched #(.NUM_mBTB(512), .QDEPTH(4), .DROP_W(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .upd_ex_v_i  (upd_ex_v_i),
    .upd_ex_i    (upd_ex_i),
    .upd_d2_v_i  (upd_d2_v_i),
    .upd_d2_i    (upd_d2_i),
    .inv_all_i   (inv_all_i),
    .wren_b0_o   (wren_b0_o),
    .wren_b1_o   (wren_b1_o),
    .addr_b0_o   (addr_b0_o),
    .addr_b1_o   (addr_b1_o),
    .wdata_b0_o  (wdata_b0_o),
    .wdata_b1_o  (wdata_b1_o),
    .init_done_o (init_done_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic exv, input logic [33:0] ex,
                       input logic d2v, input logic [33:0] d2);
    upd_ex_v_i = exv;
    upd_ex_i   = btb_t'(ex);
    upd_d2_v_i = d2v;
    upd_d2_i   = btb_t'(d2);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wren", {wren_b0_o, wren_b1_o}, 2'b00);
    chk("rst_addr0", addr_b0_o, 0);
    chk("rst_addr1", addr_b1_o, 0);
    chk("rst_wdata0", wdata_b0_o, 0);
    chk("rst_wdata1", wdata_b1_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_drop_cnt", drop_cnt_o, 0);
  endtask

  task automatic chk_sweep_step(input int k);
    a = 9'(k - 1);
    chk("sweep_ctl", {wren_b0_o, wren_b1_o, addr_b0_o, addr_b1_o, init_done_o},
        {1'b1, 1'b1, a, a, 1'b0});
    chk("sweep_data", wdata_b0_o | wdata_b1_o, 0);
  endtask

  initial begin
    exp_w = '{{1'b1, 1'b0, 16'h0100, 16'hA000}, {1'b1, 1'b0, 16'h0108, 16'hB000},
              {1'b1, 1'b0, 16'h0110, 16'hA001}, {1'b1, 1'b0, 16'h0118, 16'hB001},
              {1'b1, 1'b0, 16'h0120, 16'hA002}, {1'b1, 1'b0, 16'h0128, 16'hB002},
              {1'b1, 1'b0, 16'h0130, 16'hA003}, {1'b1, 1'b0, 16'h0140, 16'hA004}};
    exp_a = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h025, 9'h026, 9'h028};

    drive(1'b0, '0, 1'b0, '0);
    inv_all_i = 1'b0;
    #2;
    chk_reset_vals();

    // Reset release and initial sweep, with updates injected at edge 100
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= NUM; k++) begin
      if (k == 100) drive(1'b1, {1'b1, 1'b0, 16'h0010, 16'h1111},
                          1'b1, {1'b1, 1'b0, 16'h0024, 16'h2222});
      if (k == 101) drive(1'b0, '0, 1'b0, '0);
      tick();
      chk_sweep_step(k);
    end
    tick();
    chk("init_end_wren", {wren_b0_o, wren_b1_o}, 2'b00);
    chk("init_done", init_done_o, 1);
    chk("init_drop", drop_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("init_discard", {wren_b0_o, wren_b1_o}, 2'b00);
    end

    // Different banks in one cycle
    drive(1'b1, {1'b1, 1'b0, 16'h0010, 16'h1234}, 1'b1, {1'b1, 1'b1, 16'h0024, 16'h5678});
    tick();
    drive(1'b0, '0, 1'b0, '0);
    chk("diff_n_idle", {wren_b0_o, wren_b1_o}, 2'b00);
    tick();
    chk("diff_wren", {wren_b0_o, wren_b1_o}, 2'b11);
    chk("diff_addr0", addr_b0_o, 9'h002);
    chk("diff_addr1", addr_b1_o, 9'h004);
    chk("diff_wdata0", wdata_b0_o, {1'b1, 1'b0, 16'h0010, 16'h1234});
    chk("diff_wdata1", wdata_b1_o, {1'b1, 1'b1, 16'h0024, 16'h5678});
    tick();
    chk("diff_after_wren", {wren_b0_o, wren_b1_o}, 2'b00);
    chk("diff_hold_addr0", addr_b0_o, 9'h002);
    chk("diff_hold_wdata1", wdata_b1_o, {1'b1, 1'b1, 16'h0024, 16'h5678});

    // Same bank in one cycle: EX first, D2 one cycle later
    drive(1'b1, {1'b1, 1'b0, 16'h0040, 16'h1000}, 1'b1, {1'b1, 1'b0, 16'h0048, 16'h2000});
    tick();
    drive(1'b0, '0, 1'b0, '0);
    tick();
    chk("same_n1_wren", {wren_b0_o, wren_b1_o}, 2'b10);
    chk("same_n1_addr", addr_b0_o, 9'h008);
    chk("same_n1_wdata", wdata_b0_o, {1'b1, 1'b0, 16'h0040, 16'h1000});
    tick();
    chk("same_n2_wren", {wren_b0_o, wren_b1_o}, 2'b10);
    chk("same_n2_addr", addr_b0_o, 9'h009);
    chk("same_n2_wdata", wdata_b0_o, {1'b1, 1'b0, 16'h0048, 16'h2000});
    tick();
    chk("same_done", wren_b0_o, 0);

    // Overflow: five cycles of dual bank-0 updates, D2 dropped on the last two
    for (int e = 1; e <= 10; e++) begin
      if (e <= 5)
        drive(1'b1, {1'b1, 1'b0, 16'h0100 + 16'((e - 1) * 16), 16'hA000 + 16'(e - 1)},
              1'b1, {1'b1, 1'b0, 16'h0108 + 16'((e - 1) * 16), 16'hB000 + 16'(e - 1)});
      else
        drive(1'b0, '0, 1'b0, '0);
      tick();
      if (e >= 2 && e <= 9) begin
        chk("ovf_wren", {wren_b0_o, wren_b1_o}, 2'b10);
        chk("ovf_addr", addr_b0_o, exp_a[e-2]);
        chk("ovf_wdata", wdata_b0_o, exp_w[e-2]);
      end
      if (e == 3) chk("ovf_drop_e3", drop_cnt_o, 0);
      if (e == 4) chk("ovf_drop_e4", drop_cnt_o, 1);
      if (e == 5) chk("ovf_drop_e5", drop_cnt_o, 2);
      if (e == 10) chk("ovf_drained", wren_b0_o, 0);
    end

    // Sustained overflow: counter climbs then saturates
    for (int c = 1; c <= 300; c++) begin
      drive(1'b1, {1'b1, 1'b0, 16'h0200, 16'h0001}, 1'b1, {1'b1, 1'b0, 16'h0208, 16'h0002});
      tick();
      if (c == 10) chk("sat_mid", drop_cnt_o, 9);
    end
    chk("sat_full", drop_cnt_o, 255);
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_drained", wren_b0_o, 0);

    // Invalidate with three entries queued in bank 1 and a same-cycle update
    drive(1'b1, {1'b1, 1'b0, 16'h0304, 16'hC000}, 1'b1, {1'b1, 1'b0, 16'h030C, 16'hC001});
    tick();
    chk("inv_fill1", wren_b1_o, 0);
    drive(1'b1, {1'b1, 1'b0, 16'h0314, 16'hC002}, 1'b1, {1'b1, 1'b0, 16'h031C, 16'hC003});
    tick();
    chk("inv_fill2_wren", wren_b1_o, 1);
    chk("inv_fill2_addr", addr_b1_o, 9'h060);
    drive(1'b1, {1'b1, 1'b0, 16'h0404, 16'hD000}, 1'b0, '0);
    inv_all_i = 1'b1;
    tick();
    inv_all_i = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    chk("inv_edge_wren", {wren_b0_o, wren_b1_o}, 2'b00);
    chk("inv_edge_init_done", init_done_o, 0);
    chk("inv_drop_kept", drop_cnt_o, 255);
    for (int k = 1; k <= NUM; k++) begin
      tick();
      chk_sweep_step(k);
      if (k == NUM)
        drive(1'b1, {1'b1, 1'b1, 16'h0504, 16'hCAFE}, 1'b0, '0);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0);
    chk("inv_end_wren", {wren_b0_o, wren_b1_o}, 2'b00);
    chk("inv_end_init_done", init_done_o, 1);
    tick();
    chk("post_inv_wren", {wren_b0_o, wren_b1_o}, 2'b01);
    chk("post_inv_addr", addr_b1_o, 9'h0A0);
    chk("post_inv_wdata", wdata_b1_o, {1'b1, 1'b1, 16'h0504, 16'hCAFE});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("inv_flushed", {wren_b0_o, wren_b1_o}, 2'b00);
    end

    // Asynchronous reset in the middle of an INV sweep
    inv_all_i = 1'b1;
    tick();
    inv_all_i = 1'b0;
    for (int k = 1; k <= 201; k++) tick();
    chk("midinv_addr", addr_b0_o, 200);
    chk("midinv_wren", wren_b0_o, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();
    chk_sweep_step(1);
    chk("rerst_drop", drop_cnt_o, 0);
    tick();
    chk_sweep_step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
